// File: rtl/fifo_arb_pkg.sv
// Shared types and constants for the FIFO write-port arbiter.
// Holds the arbiter state encoding, the width and ceiling of the optional
// grant counters, and a saturating increment helper for those counters.
package fifo_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_t;

    localparam int STAT_W = 16;
    localparam logic [STAT_W-1:0] STAT_SAT = 16'hFFFF;

    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
        return (v == STAT_SAT) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin picker.
// Rotates the request vector so that position i_ptr lands at bit 0, takes the
// lowest set bit of the rotated vector, then maps that offset back to an
// absolute requester index (wrapping at N). Also returns the winner one-hot.
module rr_pick #(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     i_req,
    input  logic [IDX_W-1:0] i_ptr,
    output logic [N-1:0]     o_onehot,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_valid
);

    logic [N-1:0]     w_rot;
    logic [IDX_W-1:0] w_off;
    logic [IDX_W:0]   w_sum;

    // Double-width copy shifted right by the pointer gives a wrapping rotate.
    assign w_rot = N'({i_req, i_req} >> i_ptr);

    // Priority-encode the rotated vector: lowest set bit wins.
    always_comb begin
        w_off = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (w_rot[i]) begin
                w_off = IDX_W'(i);
            end
        end
    end

    assign w_sum    = {1'b0, i_ptr} + {1'b0, w_off};
    assign o_idx    = (w_sum >= (IDX_W+1)'(N)) ? IDX_W'(w_sum - (IDX_W+1)'(N))
                                               : w_sum[IDX_W-1:0];
    assign o_valid  = |i_req;
    assign o_onehot = o_valid ? (N'(1) << o_idx) : '0;

endmodule

// File: rtl/fifo_wr_arbiter.sv
// FIFO write-port arbiter: shares one FIFO write port among NUM_REQ producers.
// Round-robin between requesters; the current owner may write up to MAX_BURST
// times back to back before arbitration reopens. Grants are combinational and
// take effect at the next rising edge; a full FIFO freezes all arbiter state.
// Optional feature macro: FIFO_ARB_STATS_EN adds per-requester saturating
// grant counters readable through stat_sel/stat_cnt.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int DATA_W    = 8,
    parameter int MAX_BURST = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        gnt,
    input  logic                      fifo_full,
    output logic                      fifo_wr_en,
    output logic [DATA_W-1:0]         fifo_din
`ifdef FIFO_ARB_STATS_EN
    ,
    input  logic [2:0]                stat_sel,
    output logic [15:0]               stat_cnt
`endif
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = 4;

    arb_state_t       r_state;
    logic [IDX_W-1:0] r_owner;
    logic [CNT_W-1:0] r_burst_cnt;
    logic [IDX_W-1:0] r_rr_ptr;

    arb_state_t       w_state_nxt;
    logic [IDX_W-1:0] w_owner_nxt;
    logic [CNT_W-1:0] w_burst_nxt;
    logic [IDX_W-1:0] w_ptr_nxt;

    logic [IDX_W-1:0] w_owner_inc;
    logic [IDX_W-1:0] w_pick_ptr;
    logic [NUM_REQ-1:0] w_pick_onehot;
    logic [IDX_W-1:0] w_pick_idx;
    logic             w_pick_valid;
    logic             w_keep;
    logic             w_take;
    logic [IDX_W-1:0] w_take_idx;

    // In IDLE the search starts at the stored pointer; during a burst a
    // re-arbitration starts just after the owner, so the owner comes last.
    assign w_owner_inc = (r_owner == IDX_W'(NUM_REQ - 1)) ? '0 : r_owner + 1'b1;
    assign w_pick_ptr  = (r_state == IDLE) ? r_rr_ptr : w_owner_inc;

    rr_pick #(
        .N     (NUM_REQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .i_req    (req),
        .i_ptr    (w_pick_ptr),
        .o_onehot (w_pick_onehot),
        .o_idx    (w_pick_idx),
        .o_valid  (w_pick_valid)
    );

    // State register: owner, burst count and pointer only move when not full.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_owner     <= '0;
            r_burst_cnt <= '0;
            r_rr_ptr    <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_owner     <= w_owner_nxt;
            r_burst_cnt <= w_burst_nxt;
            r_rr_ptr    <= w_ptr_nxt;
        end
    end

    // Next-state: continue the burst, hand over to the next winner, or go idle.
    always_comb begin
        w_state_nxt = r_state;
        w_owner_nxt = r_owner;
        w_burst_nxt = r_burst_cnt;
        w_ptr_nxt   = r_rr_ptr;
        w_keep      = 1'b0;
        w_take      = 1'b0;
        w_take_idx  = r_owner;
        if (!fifo_full) begin
            if (r_state == BURST && req[r_owner] &&
                r_burst_cnt < CNT_W'(MAX_BURST)) begin
                w_keep      = 1'b1;
                w_take      = 1'b1;
                w_burst_nxt = r_burst_cnt + 1'b1;
            end else if (w_pick_valid) begin
                w_take      = 1'b1;
                w_take_idx  = w_pick_idx;
                w_state_nxt = BURST;
                w_owner_nxt = w_pick_idx;
                w_burst_nxt = CNT_W'(1);
                if (r_state == BURST && w_pick_idx != r_owner) begin
                    w_ptr_nxt = w_owner_inc;
                end
            end else begin
                w_state_nxt = IDLE;
                if (r_state == BURST) begin
                    w_ptr_nxt = w_owner_inc;
                end
            end
        end
    end

    // Outputs: one-hot grant (suppressed in reset), write enable and data mux.
    always_comb begin
        gnt = '0;
        if (!reset && w_take) begin
            if (w_keep) begin
                gnt[r_owner] = 1'b1;
            end else begin
                gnt = w_pick_onehot;
            end
        end
        fifo_wr_en = |gnt;
        fifo_din   = fifo_wr_en ? req_data[DATA_W*int'(w_take_idx) +: DATA_W] : '0;
    end

`ifdef FIFO_ARB_STATS_EN
    logic [STAT_W-1:0] r_stat_cnt [NUM_REQ];

    // Per-requester grant counters, saturating at the top value.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                r_stat_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (gnt[i]) begin
                    r_stat_cnt[i] <= sat_inc(r_stat_cnt[i]);
                end
            end
        end
    end

    // Counter readback; selects beyond the last requester read as zero.
    always_comb begin
        stat_cnt = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (stat_sel == 3'(i)) begin
                stat_cnt = r_stat_cnt[i];
            end
        end
    end
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Testbench for fifo_wr_arbiter (NUM_REQ=4, DATA_W=8, MAX_BURST=4).
// A round-robin/burst model checks every cycle on the falling edge; directed
// sequences also carry hand-computed grant expectations.
module tb_fifo_wr_arbiter;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int MB = 4;

    logic            clk = 1'b0;
    logic            reset;
    logic [N-1:0]    req;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]    gnt;
    logic            fifo_full;
    logic            fifo_wr_en;
    logic [DW-1:0]   fifo_din;
`ifdef FIFO_ARB_STATS_EN
    logic [2:0]      stat_sel;
    logic [15:0]     stat_cnt;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    fifo_wr_arbiter #(
        .NUM_REQ   (N),
        .DATA_W    (DW),
        .MAX_BURST (MB)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .req_data   (req_data),
        .gnt        (gnt),
        .fifo_full  (fifo_full),
        .fifo_wr_en (fifo_wr_en),
        .fifo_din   (fifo_din)
`ifdef FIFO_ARB_STATS_EN
        ,
        .stat_sel   (stat_sel),
        .stat_cnt   (stat_cnt)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit m_busy;
    int m_owner;
    int m_run;
    int m_next;

    // First requester at or after 'start', walking around the ring.
    function automatic int pick(input logic [N-1:0] r, input int start);
        for (int k = 0; k < N; k++) begin
            if (r[(start + k) % N]) return (start + k) % N;
        end
        return -1;
    endfunction

    always @(negedge clk) begin
        logic [N-1:0] eg;
        int w;
        eg = '0;
        w  = -1;
        if (reset) begin
            m_busy  = 1'b0;
            m_owner = 0;
            m_run   = 0;
            m_next  = 0;
        end else if (!fifo_full) begin
            if (m_busy && req[m_owner] && m_run < MB) begin
                w = m_owner;
                m_run++;
            end else begin
                w = pick(req, m_busy ? (m_owner + 1) % N : m_next);
                if (w < 0) begin
                    if (m_busy) m_next = (m_owner + 1) % N;
                    m_busy = 1'b0;
                end else begin
                    if (m_busy && w != m_owner) m_next = (m_owner + 1) % N;
                    m_owner = w;
                    m_run   = 1;
                    m_busy  = 1'b1;
                end
            end
            if (w >= 0) eg[w] = 1'b1;
        end
        check("model_gnt", 32'(gnt), 32'(eg));
        check("model_wr_en", 32'(fifo_wr_en), 32'(|eg));
        if (w >= 0) check("model_din", 32'(fifo_din), 32'(req_data[w*DW +: DW]));
    end

    // ---------------- directed stimulus ----------------
    // Check a literal grant (and its data) for the current cycle, then advance.
    task automatic tick(input string nm, input logic [N-1:0] eg);
        #1;
        check(nm, 32'(gnt), 32'(eg));
        for (int i = 0; i < N; i++) begin
            if (eg[i]) check({nm, "_din"}, 32'(fifo_din), 32'(req_data[i*DW +: DW]));
        end
        @(posedge clk);
        #1;
    endtask

    int t1 [17] = '{0, 0, 0, 0, 1, 1, 1, 1, 2, 2, 2, 2, 3, 3, 3, 3, 0};
    int occ;
    logic wr_seen;

    initial begin
        reset     = 1'b1;
        req       = '0;
        fifo_full = 1'b0;
        req_data  = {8'hD3, 8'hC2, 8'hB1, 8'hA0};
`ifdef FIFO_ARB_STATS_EN
        stat_sel  = '0;
`endif
        repeat (2) @(posedge clk);
        #1;

        // Reset state: requests present but nothing granted.
        req = 4'b1111;
        tick("reset_gnt", 4'b0000);
        reset = 1'b0;

        // Test 1: all requesting, bursts of four rotate 0,1,2,3,0.
        for (int i = 0; i < 17; i++) tick("t1_rr", 4'(1 << t1[i]));

        // Test 2: lone requester 2 is granted every cycle, across burst limits.
        req = 4'b0100;
        repeat (10) tick("t2_solo", 4'b0100);

        // Test 3: owner 1 stalls on full, then finishes its burst of four.
        req = 4'b0010;
        tick("t3_pre", 4'b0010);
        tick("t3_pre", 4'b0010);
        req = 4'b0011;
        fifo_full = 1'b1;
        repeat (3) tick("t3_full", 4'b0000);
        fifo_full = 1'b0;
        tick("t3_resume", 4'b0010);
        tick("t3_resume", 4'b0010);
        tick("t3_handoff", 4'b0001);

        // Test 4: reset during an owner-3 burst; requester 0 wins afterwards.
        req = 4'b1000;
        tick("t4_own3", 4'b1000);
        req = 4'b1001;
        tick("t4_own3", 4'b1000);
        reset = 1'b1;
        tick("t4_reset", 4'b0000);
        reset = 1'b0;
        tick("t4_after", 4'b0001);

        // Test 5: owner 0 drops after two grants, requester 3 takes over at once.
        tick("t5_own0", 4'b0001);
        req = 4'b1000;
        tick("t5_switch", 4'b1000);
        occ = 0;
        for (int i = 0; i < 20; i++) begin
            fifo_full = (occ >= 16);
            #1;
            wr_seen = fifo_wr_en;
            tick("t5_fill", (occ < 16) ? 4'b1000 : 4'b0000);
            if (wr_seen) occ++;
        end
        check("t5_occ", 32'(occ), 32'd16);
        fifo_full = 1'b0;
        req = 4'b0000;
        tick("t5_idle", 4'b0000);

`ifdef FIFO_ARB_STATS_EN
        // Test 6: grant counters.
        reset = 1'b1;
        req = 4'b1111;
        tick("t6_reset", 4'b0000);
        reset = 1'b0;
        for (int i = 0; i < 32; i++) tick("t6_rr", 4'(1 << ((i / 4) % 4)));
        for (int s = 0; s < 4; s++) begin
            stat_sel = 3'(s);
            #1;
            check("t6_cnt", 32'(stat_cnt), 32'd8);
        end
        stat_sel = 3'd5;
        #1;
        check("t6_sel5", 32'(stat_cnt), 32'd0);
        req = 4'b0000;
        tick("t6_idle", 4'b0000);
        dut.r_stat_cnt[0] = 16'hFFFF;
        req = 4'b0001;
        tick("t6_sat_gnt", 4'b0001);
        req = 4'b0000;
        stat_sel = 3'd0;
        #1;
        check("t6_sat", 32'(stat_cnt), 32'h0000FFFF);
        stat_sel = 3'd1;
        #1;
        check("t6_cnt1", 32'(stat_cnt), 32'd8);
`endif

        repeat (2) @(posedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
